// File: rtl/disp_filt_pkg.sv
// Shared types for the disparity filtering chain.
package disp_filt_pkg;
  typedef logic [7:0] pix_t;
  typedef enum logic [1:0] {FILL, RUN, FLUSH} med_state_t;
endpackage

// File: rtl/median9.sv
// Combinational median of nine pixels via a 19 compare-exchange network.
module median9
  import disp_filt_pkg::*;
(
  input  pix_t [8:0] pix_i,
  output pix_t       med_o
);
  // each entry orders the pair so that p[CA] <= p[CB]
  localparam int CA [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int CB [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  pix_t p [9];
  pix_t t;

  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = pix_i[i];
    t = '0;
    for (int i = 0; i < 19; i++) begin
      if (p[CA[i]] > p[CB[i]]) begin
        t        = p[CA[i]];
        p[CA[i]] = p[CB[i]];
        p[CB[i]] = t;
      end
    end
  end

  assign med_o = p[4];
endmodule

// File: rtl/median3x3_stream.sv
// 3x3 median filter on a raster disparity stream; border pixels pass through.
module median3x3_stream
  import disp_filt_pkg::*;
#(
  parameter int in_width  = 120,
  parameter int in_height = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  localparam int CW = $clog2(in_width);
  localparam int RW = $clog2(in_height);
  localparam logic [CW-1:0] COL_LAST = CW'(in_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(in_height - 1);

  med_state_t      state_q, state_d;
  logic [CW-1:0]   col_q, col_d, ocol_q, ocol_d, rd_addr;
  logic [RW-1:0]   row_q, row_d, orow_q, orow_d;
  logic            last_q, last_d, out_valid_q, out_valid_d;
  pix_t            out_data_q, out_data_d;
  pix_t [2:0][1:0] hist_q, hist_d;
  pix_t            lba [in_width];
  pix_t            lbb [in_width];
  pix_t            rda_q, rdb_q, new_pix, med;
  pix_t [8:0]      win;
  logic            slot_free, adv, load, wr, border;

  assign slot_free = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Window = two stored columns plus the column being shifted in this cycle.
  assign win = {new_pix, hist_q[2][1], hist_q[2][0],
                rda_q,   hist_q[1][1], hist_q[1][0],
                rdb_q,   hist_q[0][1], hist_q[0][0]};

  median9 u_med (.pix_i(win), .med_o(med));

  assign border = (ocol_q == '0) || (ocol_q == COL_LAST) ||
                  (orow_q == '0) || (orow_q == ROW_LAST);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    hist_d      = hist_q;
    in_ready    = 1'b0;
    adv         = 1'b0;
    load        = 1'b0;
    wr          = 1'b0;
    new_pix     = in_data;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          adv = 1'b1;
          wr  = 1'b1;
          if (col_q == '0 && row_q == RW'(1)) state_d = RUN;
        end
      end
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          adv  = 1'b1;
          wr   = 1'b1;
          load = 1'b1;
          if (col_q == COL_LAST && row_q == ROW_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Remaining outputs are all bottom/right border, so the filler pixel never matters.
        new_pix = '0;
        if (!last_q && slot_free) begin
          adv  = 1'b1;
          load = 1'b1;
          if (ocol_q == COL_LAST && orow_q == ROW_LAST) last_d = 1'b1;
        end else if (last_q && out_valid_q && out_ready) begin
          state_d = FILL;
          last_d  = 1'b0;
          col_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase

    if (adv) begin
      for (int r = 0; r < 3; r++) hist_d[r][0] = hist_q[r][1];
      hist_d[0][1] = rdb_q;
      hist_d[1][1] = rda_q;
      hist_d[2][1] = new_pix;
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      if (state_q != FLUSH && col_q == COL_LAST)
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = border ? hist_q[1][1] : med;
      ocol_d      = (ocol_q == COL_LAST) ? '0 : ocol_q + 1'b1;
      if (ocol_q == COL_LAST) orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Read one column ahead so the RAM output lines up with the next accept.
  assign rd_addr = reset ? '0 : col_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && !reset) hist_q <= hist_d;
    if (wr && !reset) begin
      lba[col_q] <= in_data;
      lbb[col_q] <= rda_q;
    end
    rda_q <= lba[rd_addr];
    rdb_q <= lbb[rd_addr];
  end
endmodule

// File: tb/tb_median3x3_stream.sv
// Randomized bench for median3x3_stream against a direct 3x3-median frame model.
module tb_median3x3_stream;
  localparam int W = 4, H = 4, N = W * H;
  localparam int BW = 120, BH = 240, BN = BW * BH;

  typedef logic [7:0] pq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_data, out_data, b_in_data, b_out_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;

  median3x3_stream #(.in_width(W), .in_height(H)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  median3x3_stream #(.in_width(BW), .in_height(BH)) dut_big (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready));

  int   n_chk = 0, n_err = 0;
  pq_t  got;
  int   acc_cyc [$];
  int   out_cyc [$];

  task automatic tb_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: border -> pixel itself, interior -> rank-4 value of its 3x3 neighbourhood.
  function automatic pq_t golden(input int w, input int h, input pq_t f);
    pq_t o;
    logic [7:0] v [9];
    logic [7:0] m;
    int lt, le;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (r == 0 || r == h - 1 || c == 0 || c == w - 1) o.push_back(f[r*w+c]);
        else begin
          for (int k = 0; k < 9; k++) v[k] = f[(r + k/3 - 1)*w + c + k%3 - 1];
          m = 8'd0;
          for (int i = 0; i < 9; i++) begin
            lt = 0; le = 0;
            for (int j = 0; j < 9; j++) begin
              if (v[j] <  v[i]) lt++;
              if (v[j] <= v[i]) le++;
            end
            if (lt <= 4 && le >= 5) m = v[i];
          end
          o.push_back(m);
        end
      end
    return o;
  endfunction

  task automatic run_small(input pq_t px, input int vprob, input bit pat);
    int ai = 0, cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_d = 8'd0;
    got = {}; acc_cyc = {}; out_cyc = {};
    while (got.size() < px.size() && cyc < 3000) begin
      @(negedge clk);
      if (prev_stall) begin
        tb_chk("hold_valid", {31'd0, out_valid}, 32'd1);
        tb_chk("hold_data", {24'd0, out_data}, {24'd0, prev_d});
      end
      in_valid  = (ai < px.size()) && ($urandom_range(99) < vprob);
      in_data   = (ai < px.size()) ? px[ai] : 8'd0;
      out_ready = pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (ai > 0 && ai % N == 0 && got.size() < ai) tb_chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) begin acc_cyc.push_back(cyc); ai++; end
      if (out_valid && out_ready) begin got.push_back(out_data); out_cyc.push_back(cyc); end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      cyc++;
    end
    tb_chk("timeout_small", cyc < 3000, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cmp_frames(input string tag, input pq_t exp);
    tb_chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      tb_chk($sformatf("%s_px%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    pq_t px, exp, frame, bpx, bexp;
    int k, guard, bi, cyc, bubbles, nbad, first_bad;
    bit started;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    tb_chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    tb_chk("reset_out_data", {24'd0, out_data}, 32'd0);
    tb_chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tb_chk("reset_big_valid", {31'd0, b_out_valid}, 32'd0);

    // 1: constant frame, latency of first and last outputs
    px = {};
    for (int i = 0; i < N; i++) px.push_back(8'd50);
    run_small(px, 100, 1'b0);
    cmp_frames("const", px);
    if (acc_cyc.size() == N && out_cyc.size() == N) begin
      tb_chk("first_latency", out_cyc[0], acc_cyc[W+1] + 1);
      tb_chk("flush_latency", out_cyc[N-1], acc_cyc[N-1] + W + 2);
    end else tb_chk("latency_samples", acc_cyc.size() + out_cyc.size(), 2 * N);

    // 2: ramp frame
    px = {};
    for (int i = 0; i < N; i++) px.push_back(8'(i));
    run_small(px, 100, 1'b0);
    cmp_frames("ramp", golden(W, H, px));
    tb_chk("ramp_med11", {24'd0, got[5]}, 32'd5);
    tb_chk("ramp_med12", {24'd0, got[6]}, 32'd6);
    tb_chk("ramp_med21", {24'd0, got[9]}, 32'd9);
    tb_chk("ramp_med22", {24'd0, got[10]}, 32'd10);

    // 3: interior speck removed, border speck kept
    px = {};
    for (int i = 0; i < N; i++) px.push_back(8'd10);
    px[5] = 8'd255;
    run_small(px, 100, 1'b0);
    tb_chk("speck_interior", {24'd0, got[5]}, 32'd10);
    cmp_frames("speck_in", golden(W, H, px));
    px[5] = 8'd10; px[0] = 8'd255;
    run_small(px, 100, 1'b0);
    tb_chk("speck_border", {24'd0, got[0]}, 32'd255);
    cmp_frames("speck_bd", golden(W, H, px));

    // 4: three back-to-back random frames, random in_valid, out_ready pattern 1,0,0,1
    px = {}; exp = {};
    for (int f = 0; f < 3; f++) begin
      frame = {};
      for (int i = 0; i < N; i++) frame.push_back(8'($urandom_range(255)));
      px  = {px, frame};
      exp = {exp, golden(W, H, frame)};
    end
    run_small(px, 60, 1'b1);
    cmp_frames("rand3", exp);

    // 5: reset mid-frame then a clean ramp frame
    k = 0; guard = 0;
    while (k < 7 && guard < 100) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(k); out_ready = 1'b1;
      #1;
      if (in_ready) k++;
      guard++;
    end
    tb_chk("midreset_accepts", k, 32'd7);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tb_chk("midreset_valid", {31'd0, out_valid}, 32'd0);
    tb_chk("midreset_data", {24'd0, out_data}, 32'd0);
    px = {};
    for (int i = 0; i < N; i++) px.push_back(8'(i));
    run_small(px, 100, 1'b0);
    cmp_frames("restart", golden(W, H, px));

    // 6: full-size random frame at full rate
    bpx = {};
    for (int i = 0; i < BN; i++) bpx.push_back(8'($urandom_range(255)));
    bexp = golden(BW, BH, bpx);
    got = {}; bi = 0; cyc = 0; bubbles = 0; started = 1'b0;
    while (got.size() < BN && cyc < 40000) begin
      @(negedge clk);
      b_in_valid  = bi < BN;
      b_in_data   = (bi < BN) ? bpx[bi] : 8'd0;
      b_out_ready = 1'b1;
      #1;
      if (b_in_valid && b_in_ready) bi++;
      if (b_out_valid) begin got.push_back(b_out_data); started = 1'b1; end
      else if (started) bubbles++;
      cyc++;
    end
    b_in_valid = 1'b0;
    tb_chk("timeout_big", cyc < 40000, 32'd1);
    tb_chk("big_count", got.size(), BN);
    tb_chk("big_bubbles", bubbles, 32'd0);
    nbad = 0; first_bad = -1;
    for (int i = 0; i < BN && i < got.size(); i++)
      if (got[i] !== bexp[i]) begin
        if (first_bad < 0) first_bad = i;
        nbad++;
      end
    tb_chk("big_bad_pixels", nbad, 32'd0);
    if (first_bad >= 0) tb_chk($sformatf("big_px%0d", first_bad), {24'd0, got[first_bad]}, {24'd0, bexp[first_bad]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
